// File: rtl/spb_router.sv
// spb_router: forwards one outstanding upstream SPB request to one of N_PORTS downstream ports,
// selected by an address field. Optional downstream wait timeout: define SPB_ROUTER_TIMEOUT_EN.
module spb_router #(
   parameter int N_PORTS = 4,
   parameter int SEL_LSB = 28,
   parameter int TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  S_SPB_VALID,
   input  logic [31:0]           S_SPB_ADDR,
   input  logic [31:0]           S_SPB_WDATA,
   input  logic [3:0]            S_SPB_WSTB,
   output logic                  S_SPB_READY,
   output logic [31:0]           S_SPB_RDATA,
   output logic                  S_SPB_EXCPT,
   output logic [N_PORTS-1:0]    M_SPB_VALID,
   output logic [31:0]           M_SPB_ADDR,
   output logic [31:0]           M_SPB_WDATA,
   output logic [3:0]            M_SPB_WSTB,
   input  logic [N_PORTS-1:0]    M_SPB_READY,
   input  logic [N_PORTS-1:0]    M_SPB_EXCPT,
   input  logic [32*N_PORTS-1:0] M_SPB_RDATA
);

   localparam int SelW = $clog2(N_PORTS);
   localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_t;

   state_t             state_q;
   logic [SelW-1:0]    idx_q;
   logic [N_PORTS-1:0] mValid_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         wstb_q;
   logic               sReady_q;
   logic               sExcpt_q;
   logic [31:0]        sRdata_q;

   logic [SelW-1:0]    selField;
   logic [N_PORTS-1:0] selOneHot;
   logic               selOk;
   logic               portReady;
   logic               portExcpt;
   logic [31:0]        portRdata;
   logic               timedOut;

   // Decode the incoming select field and mux back the response of the latched port.
   always_comb begin
      selField  = S_SPB_ADDR[SEL_LSB +: SelW];
      selOneHot = '0;
      portReady = 1'b0;
      portExcpt = 1'b0;
      portRdata = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (selField == SelW'(k)) begin
            selOneHot[k] = 1'b1;
         end
         if (idx_q == SelW'(k)) begin
            portReady = M_SPB_READY[k];
            portExcpt = M_SPB_EXCPT[k];
            portRdata = M_SPB_RDATA[32*k +: 32];
         end
      end
      selOk = |selOneHot;
   end

`ifdef SPB_ROUTER_TIMEOUT_EN
   logic [15:0] waitCnt_q;
   assign timedOut = (waitCnt_q == 16'(TIMEOUT));
`else
   assign timedOut = 1'b0;
`endif

   // Single FSM; every output is a register so the upstream and downstream see glitch-free signals.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         mValid_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstb_q   <= '0;
         sReady_q <= 1'b0;
         sExcpt_q <= 1'b0;
         sRdata_q <= '0;
`ifdef SPB_ROUTER_TIMEOUT_EN
         waitCnt_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (S_SPB_VALID) begin
                  addr_q  <= S_SPB_ADDR;
                  wdata_q <= S_SPB_WDATA;
                  wstb_q  <= S_SPB_WSTB;
                  if (selOk) begin
                     idx_q    <= selField;
                     mValid_q <= selOneHot;
                     state_q  <= FWD;
`ifdef SPB_ROUTER_TIMEOUT_EN
                     waitCnt_q <= '0;
`endif
                  end else begin
                     sReady_q <= 1'b1;
                     sExcpt_q <= 1'b1;
                     sRdata_q <= ErrData;
                     state_q  <= ERR;
                  end
               end
            end
            FWD: begin
               // A READY in the same cycle as the timeout limit still completes normally.
               if (portReady) begin
                  mValid_q <= '0;
                  sReady_q <= 1'b1;
                  sExcpt_q <= portExcpt;
                  sRdata_q <= portRdata;
                  state_q  <= RESP;
               end else if (timedOut) begin
                  mValid_q <= '0;
                  sReady_q <= 1'b1;
                  sExcpt_q <= 1'b1;
                  sRdata_q <= ErrData;
                  state_q  <= ERR;
               end else begin
`ifdef SPB_ROUTER_TIMEOUT_EN
                  waitCnt_q <= waitCnt_q + 16'd1;
`endif
               end
            end
            RESP, ERR: begin
               sReady_q <= 1'b0;
               sExcpt_q <= 1'b0;
               sRdata_q <= '0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign S_SPB_READY = sReady_q;
   assign S_SPB_RDATA = sRdata_q;
   assign S_SPB_EXCPT = sExcpt_q;
   assign M_SPB_VALID = mValid_q;
   assign M_SPB_ADDR  = addr_q;
   assign M_SPB_WDATA = wdata_q;
   assign M_SPB_WSTB  = wstb_q;

endmodule

// File: tb/tb_spb_router.sv
// tb_spb_router: directed bench for spb_router with a cycle-timeline model of expected outputs.
// Instance 0 has 4 ports, instance 1 has 3 ports (for decode errors).
module tb_spb_router;

   localparam int MaxCyc  = 600;
   localparam int SelLsb  = 28;
   localparam int Timeout = 8;

   typedef struct packed {
      logic [7:0]  mValid;
      logic        sReady;
      logic [31:0] rdata;
      logic        excpt;
      logic        chkBus;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstb;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   nChecks = 0;
   int   nFails = 0;
   bit   checking = 1'b0;

   logic         sValid [2];
   logic [31:0]  sAddr  [2];
   logic [31:0]  sWdata [2];
   logic [3:0]   sWstb  [2];
   logic [7:0]   mReady [2];
   logic [7:0]   mExcpt [2];
   logic [255:0] mRdata [2];

   logic        aSReady, bSReady, aSExcpt, bSExcpt;
   logic [31:0] aSRdata, bSRdata, aMAddr, bMAddr, aMWdata, bMWdata;
   logic [3:0]  aMWstb, bMWstb, aMValid;
   logic [2:0]  bMValid;

   exp_t expTab [2][MaxCyc];
   exp_t obs [2];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   spb_router #(.N_PORTS(4), .SEL_LSB(SelLsb), .TIMEOUT(Timeout)) dut (
      .CLK(CLK), .RST(RST),
      .S_SPB_VALID(sValid[0]), .S_SPB_ADDR(sAddr[0]), .S_SPB_WDATA(sWdata[0]), .S_SPB_WSTB(sWstb[0]),
      .S_SPB_READY(aSReady), .S_SPB_RDATA(aSRdata), .S_SPB_EXCPT(aSExcpt),
      .M_SPB_VALID(aMValid), .M_SPB_ADDR(aMAddr), .M_SPB_WDATA(aMWdata), .M_SPB_WSTB(aMWstb),
      .M_SPB_READY(mReady[0][3:0]), .M_SPB_EXCPT(mExcpt[0][3:0]), .M_SPB_RDATA(mRdata[0][127:0])
   );

   spb_router #(.N_PORTS(3), .SEL_LSB(SelLsb), .TIMEOUT(Timeout)) dut3 (
      .CLK(CLK), .RST(RST),
      .S_SPB_VALID(sValid[1]), .S_SPB_ADDR(sAddr[1]), .S_SPB_WDATA(sWdata[1]), .S_SPB_WSTB(sWstb[1]),
      .S_SPB_READY(bSReady), .S_SPB_RDATA(bSRdata), .S_SPB_EXCPT(bSExcpt),
      .M_SPB_VALID(bMValid), .M_SPB_ADDR(bMAddr), .M_SPB_WDATA(bMWdata), .M_SPB_WSTB(bMWstb),
      .M_SPB_READY(mReady[1][2:0]), .M_SPB_EXCPT(mExcpt[1][2:0]), .M_SPB_RDATA(mRdata[1][95:0])
   );

   // Gather both instances' outputs into one shape so a single compare loop covers them.
   always_comb begin
      obs[0] = '0;
      obs[1] = '0;
      obs[0].mValid = {4'b0, aMValid};
      obs[0].sReady = aSReady;
      obs[0].rdata  = aSRdata;
      obs[0].excpt  = aSExcpt;
      obs[0].addr   = aMAddr;
      obs[0].wdata  = aMWdata;
      obs[0].wstb   = aMWstb;
      obs[1].mValid = {5'b0, bMValid};
      obs[1].sReady = bSReady;
      obs[1].rdata  = bSRdata;
      obs[1].excpt  = bSExcpt;
      obs[1].addr   = bMAddr;
      obs[1].wdata  = bMWdata;
      obs[1].wstb   = bMWstb;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChecks++;
      if (act !== expv) begin
         nFails++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, expv);
      end
   endtask

   // Every cycle, compare both instances against the expected timeline.
   always @(negedge CLK) begin
      exp_t e;
      if (checking) begin
         if (cyc >= MaxCyc) begin
            checkOutput("cycleBudget", 32'(cyc), 32'(MaxCyc - 1));
         end else begin
            for (int d = 0; d < 2; d++) begin
               e = expTab[d][cyc];
               checkOutput($sformatf("d%0d.mValid", d), 32'(obs[d].mValid), 32'(e.mValid));
               checkOutput($sformatf("d%0d.sReady", d), 32'(obs[d].sReady), 32'(e.sReady));
               checkOutput($sformatf("d%0d.sRdata", d), obs[d].rdata, e.rdata);
               checkOutput($sformatf("d%0d.sExcpt", d), 32'(obs[d].excpt), 32'(e.excpt));
               if (e.chkBus) begin
                  checkOutput($sformatf("d%0d.mAddr", d), obs[d].addr, e.addr);
                  checkOutput($sformatf("d%0d.mWdata", d), obs[d].wdata, e.wdata);
                  checkOutput($sformatf("d%0d.mWstb", d), 32'(obs[d].wstb), 32'(e.wstb));
               end
            end
         end
      end
   end

   // Runs one transaction on instance d, entered #1 after a rising edge with the DUT idle.
   // Writes the expected timeline derived from the protocol rules, then drives both sides.
   task automatic applyStimulus(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstb, input int readyDelay,
                                input logic [31:0] rdata, input logic dExcpt, input bit abort2);
      int   c0, nPorts, sel, fwdLen, respAt;
      bit   isErr, timedOut;
      logic [7:0] oneHot;
      c0       = cyc;
      nPorts   = (d == 0) ? 4 : 3;
      sel      = int'((addr >> SelLsb) % 4);
      isErr    = (sel >= nPorts);
      timedOut = 1'b0;
`ifdef SPB_ROUTER_TIMEOUT_EN
      if (!isErr && readyDelay > Timeout) timedOut = 1'b1;
`endif
      oneHot = isErr ? 8'h00 : 8'(1 << sel);
      if (isErr)         fwdLen = 0;
      else if (abort2)   fwdLen = 2;
      else if (timedOut) fwdLen = Timeout + 1;
      else               fwdLen = readyDelay + 1;
      respAt = c0 + fwdLen + 1;
      for (int c = c0 + 1; c <= c0 + fwdLen; c++) begin
         expTab[d][c].mValid = oneHot;
         expTab[d][c].chkBus = 1'b1;
         expTab[d][c].addr   = addr;
         expTab[d][c].wdata  = wdata;
         expTab[d][c].wstb   = wstb;
      end
      if (!abort2) begin
         expTab[d][respAt].sReady = 1'b1;
         expTab[d][respAt].excpt  = (isErr || timedOut) ? 1'b1 : dExcpt;
         expTab[d][respAt].rdata  = (isErr || timedOut) ? 32'hDEAD_BEEF : rdata;
      end
      sValid[d] = 1'b1;
      sAddr[d]  = addr;
      sWdata[d] = wdata;
      sWstb[d]  = wstb;
      for (int k = 1; k <= fwdLen + 1; k++) begin
         @(posedge CLK);
         #1;
         RST       = 1'b0;
         mReady[d] = '0;
         mExcpt[d] = '0;
         mRdata[d] = '0;
         if (k <= fwdLen) begin
            sAddr[d]  = ~addr;
            sWdata[d] = ~wdata;
            sWstb[d]  = ~wstb;
            mReady[d] = ~oneHot;
            mExcpt[d] = ~oneHot;
            mRdata[d] = '1;
            if (!timedOut && !abort2 && k == readyDelay + 1) begin
               mReady[d][sel]            = 1'b1;
               mExcpt[d][sel]            = dExcpt;
               mRdata[d][sel*32 +: 32]   = rdata;
            end
            if (abort2 && k == 2) RST = 1'b1;
         end else if (abort2) begin
            sValid[d] = 1'b0;
         end
      end
      if (!abort2) begin
         @(posedge CLK);
         #1;
         sValid[d] = 1'b0;
      end
   endtask

   int n;

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < MaxCyc; i++) expTab[d][i] = '0;
         sValid[d] = 1'b0;
         sAddr[d]  = '0;
         sWdata[d] = '0;
         sWstb[d]  = '0;
         mReady[d] = '0;
         mExcpt[d] = '0;
         mRdata[d] = '0;
      end
      RST = 1'b1;
      @(posedge CLK);
      checking = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      checkOutput("rstMValid", 32'(aMValid), 32'h0);
      checkOutput("rstSReady", 32'(aSReady), 32'h0);
      checkOutput("rstSRdata", aSRdata, 32'h0);
      checkOutput("rstMAddr", aMAddr, 32'h0);
      checkOutput("rstMWdata", aMWdata, 32'h0);

      // Read from port 1, READY on the first forward cycle.
      fork
         applyStimulus(0, 32'h1000_0010, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 1'b0);
         begin
            repeat (2) @(negedge CLK);
            checkOutput("rdMValid", 32'(aMValid), 32'h2);
            @(negedge CLK);
            checkOutput("rdSReady", 32'(aSReady), 32'h1);
            checkOutput("rdSRdata", aSRdata, 32'h1234_5678);
            checkOutput("rdSExcpt", 32'(aSExcpt), 32'h0);
         end
      join
      @(posedge CLK);
      #1;

      // Write to port 3 with READY delayed 5 cycles.
      n = 0;
      fork
         applyStimulus(0, 32'h3000_0000, 32'hA5A5_0F0F, 4'b0011, 5, 32'h0, 1'b0, 1'b0);
         repeat (10) begin
            @(negedge CLK);
            if (aMValid[3] && aMWdata == 32'hA5A5_0F0F && aMWstb == 4'b0011) n++;
         end
      join
      checkOutput("wrFwdCycles", 32'(n), 32'd6);
      @(posedge CLK);
      #1;

      // Decode error on the 3-port instance.
      fork
         applyStimulus(1, 32'h3000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
         begin
            repeat (2) @(negedge CLK);
            checkOutput("errSReady", 32'(bSReady), 32'h1);
            checkOutput("errSExcpt", 32'(bSExcpt), 32'h1);
            checkOutput("errSRdata", bSRdata, 32'hDEAD_BEEF);
            checkOutput("errMValid", 32'(bMValid), 32'h0);
         end
      join
      @(posedge CLK);
      #1;

      // Normal transaction on the 3-port instance, highest legal port.
      applyStimulus(1, 32'h2000_0008, 32'h0, 4'h0, 2, 32'h3333_3333, 1'b0, 1'b0);

      // Back-to-back: port 0 read then port 2 write with no idle gap from the bench.
      applyStimulus(0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0, 1'b0);
      applyStimulus(0, 32'h2000_0200, 32'hFEED_0001, 4'hF, 1, 32'h2222_2222, 1'b0, 1'b0);

      // Downstream exception, READY exactly at the timeout limit still completes normally.
      applyStimulus(0, 32'h2000_0004, 32'h0, 4'h0, Timeout, 32'hCAFE_F00D, 1'b1, 1'b0);

      // Reset in the second forward cycle aborts silently; the next request is served.
      fork
         applyStimulus(0, 32'h1000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b1);
         begin
            repeat (4) @(negedge CLK);
            checkOutput("abortMValid", 32'(aMValid), 32'h0);
            checkOutput("abortMAddr", aMAddr, 32'h0);
            checkOutput("abortSReady", 32'(aSReady), 32'h0);
         end
      join
      @(posedge CLK);
      #1;
      applyStimulus(0, 32'h1000_0020, 32'h0, 4'h0, 0, 32'h4444_4444, 1'b0, 1'b0);

`ifdef SPB_ROUTER_TIMEOUT_EN
      // Port 0 never answers: timeout error, then a late READY pulse must be ignored.
      n = 0;
      fork
         begin
            applyStimulus(0, 32'h0000_0040, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 1'b0);
            @(posedge CLK);
            #1;
            mReady[0][0]    = 1'b1;
            mRdata[0][31:0] = 32'h5555_5555;
            @(posedge CLK);
            #1;
            mReady[0] = '0;
            mRdata[0] = '0;
         end
         for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (aMValid[0]) n++;
            if (i == 10) begin
               checkOutput("toSReady", 32'(aSReady), 32'h1);
               checkOutput("toSRdata", aSRdata, 32'hDEAD_BEEF);
            end
         end
      join
      checkOutput("toFwdCycles", 32'(n), 32'd9);
      @(posedge CLK);
      #1;
`endif

      repeat (3) @(posedge CLK);
      #1;
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
